vital_risk_encoder: RTL and testbench
=====================================

// Module: vital_risk_encoder
// PURPOSE
//  Sensor-side producer of the six risk flags H,P,O,T,R,B consumed by fsm_vital_sign.
//  Accepts time-multiplexed raw sensor samples over a valid/ready channel.
//  Window-checks each sample against per-channel limits and applies a persistence filter.
//  Drives one registered risk bit per channel.
// PARAMETERS
//  DW         12          sample width (unsigned)
//  PERSIST    3           consecutive disagreeing samples needed to toggle a flag (>=1)
//  LO_LIMITS  6*DW bits   packed lower limits; slice [c*DW +: DW] belongs to channel c
//  HI_LIMITS  6*DW bits   packed upper limits, same packing
//  STALE_CYC  1000        cycles without a sample before a channel is stale (RISK_STALE_EN only)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  s_valid    in   1   sample valid
//  s_ready    out  1   sample accepted when s_valid & s_ready
//  s_chan     in   3   0=H 1=P 2=O 3=T 4=R 5=B; 6,7 illegal
//  s_data     in   DW  raw sample
//  H,P,O,T,R,B out 1   risk flags, 1 = risk
//  err_chan   out  1   1-cycle pulse: illegal channel accepted
//  scan_done  out  1   1-cycle pulse: channel-5 sample processed
// BEHAVIOUR
//  - One clock domain, clk. Synchronous active-high reset.
//  - Reset: all flags, err_chan, scan_done and every counter = 0; s_ready = 0 while reset=1.
//  - s_ready = ~reset. No other backpressure; one sample accepted per cycle.
//  - Out-of-range test: oor = (s_data < LO[c]) | (s_data > HI[c]). Unsigned; limits inclusive in-range.
//  - Per channel: 'dis' counter, width clog2(PERSIST+1).
//    - Sample with oor == flag[c] (agrees): dis = 0.
//    - Disagreeing sample, dis == PERSIST-1: flag[c] toggles, dis = 0.
//    - Other disagreeing sample: dis++.
//  - PERSIST=1: every disagreeing sample toggles the flag immediately.
//  - Latency: flag, err_chan and scan_done update on the clk edge that accepts the sample.
//    Visible 1 cycle after the handshake.
//  - Only the addressed channel's counter and flag change; others hold.
//  - Illegal s_chan (6,7): sample consumed, no state change, err_chan = 1 for one cycle.
//  - scan_done pulses for any accepted channel-5 sample; no ordering of channels is enforced.
//  - Reset mid-stream: sample presented in a reset cycle is discarded; partial dis counts are lost.
//  - Flags are level outputs, held until toggled or reset. Drive fsm_vital_sign H..B directly.
// CONFIGURATION
//  RISK_STALE_EN defined:
//    - Per-channel stale counter, saturating at STALE_CYC. Cleared to 0 by any accepted sample
//      on that channel.
//    - On the cycle it reaches STALE_CYC: flag[c] = 1, dis[c] = 0 (lost sensor = risk).
//      Sticky; a later in-range stream clears the flag via normal persistence.
//    - Same-cycle sample on channel c has priority: the counter clears, no force.
//  RISK_STALE_EN undefined:
//    - No stale counters, STALE_CYC unused.
//    - Flags change only through samples.
// TESTING  (DW=12, PERSIST=3, H limits 50..120, all other limits 0..4095, STALE_CYC=20)
//  1 Reset 2 cycles -> all flags 0, s_ready 0 in reset, 1 the cycle after release.
//  2 chan0 data 130,130 -> H stays 0; third 130 -> H=1 one cycle after handshake.
//  3 H=1; chan0 data 80,80,130,80,80,80 -> H stays 1 until 6th sample, then H=0
//    (130 resets dis).
//  4 chan0 data 50 and 120 x3 -> H stays 0 (inclusive limits).
//    chan0 data 49 x3 -> H=1.
//  5 s_chan=6, data 0 -> err_chan pulses one cycle, no flag changes.
//    chan5 sample -> scan_done pulses.
//  6 RISK_STALE_EN: no chan3 sample for 20 cycles -> T=1.
//    Then chan3 in-range x3 -> T=0.
//    Without the macro: T stays 0.

Source files
------------

// File: rtl/vital_risk_encoder.sv
// vital_risk_encoder
// Sensor-side producer of the six risk flags (H,P,O,T,R,B) that drive fsm_vital_sign.
// Time-multiplexed raw samples arrive over a valid/ready channel. Each sample is
// window-checked against its channel's limits. A persistence filter then toggles that
// channel's registered risk flag only after PERSIST consecutive disagreeing samples.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   s_valid/s_ready      sample handshake (s_ready = ~reset, no other backpressure)
//   s_chan, s_data       channel index (0..5 legal, 6/7 illegal) and raw unsigned sample
//   H,P,O,T,R,B          level risk flags, 1 = risk
//   err_chan             1-cycle pulse when an illegal channel sample is accepted
//   scan_done            1-cycle pulse when a channel-5 sample is accepted
//
// Optional feature: define RISK_STALE_EN to force a channel's flag to risk after
// STALE_CYC cycles without a sample on that channel.
module vital_risk_encoder #(
    parameter int unsigned         DW        = 12,
    parameter int unsigned         PERSIST   = 3,
    parameter logic [6*DW-1:0]     LO_LIMITS = '0,
    parameter logic [6*DW-1:0]     HI_LIMITS = '1,
    parameter int unsigned         STALE_CYC = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [2:0]    s_chan,
    input  logic [DW-1:0] s_data,
    output logic          H,
    output logic          P,
    output logic          O,
    output logic          T,
    output logic          R,
    output logic          B,
    output logic          err_chan,
    output logic          scan_done
);

    localparam int unsigned CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] DisLast = CW'(PERSIST - 1);

    logic          accept;
    logic [5:0]    hit;
    logic [5:0]    oor;
    logic [5:0]    flag_q, flag_d;
    logic [CW-1:0] dis_q [6];
    logic [CW-1:0] dis_d [6];
    logic          err_q, done_q;

    assign s_ready = ~reset;
    assign accept  = s_valid & s_ready;

    // Per-channel window test; only the addressed channel's result is used.
    always_comb begin
        hit = '0;
        oor = '0;
        for (int c = 0; c < 6; c++) begin
            hit[c] = accept && (s_chan == 3'(c));
            oor[c] = (s_data < LO_LIMITS[c*DW +: DW]) | (s_data > HI_LIMITS[c*DW +: DW]);
        end
    end

`ifdef RISK_STALE_EN
    localparam int unsigned SW = $clog2(STALE_CYC + 1);
    localparam logic [SW-1:0] StaleMax = SW'(STALE_CYC);

    logic [SW-1:0] stale_q [6];
    logic [SW-1:0] stale_d [6];
`endif

    always_comb begin
        flag_d = flag_q;
        for (int c = 0; c < 6; c++) begin
            dis_d[c] = dis_q[c];
            if (hit[c]) begin
                if (oor[c] == flag_q[c]) begin
                    dis_d[c] = '0;
                end else if (dis_q[c] == DisLast) begin
                    flag_d[c] = ~flag_q[c];
                    dis_d[c]  = '0;
                end else begin
                    dis_d[c] = dis_q[c] + 1'b1;
                end
            end
`ifdef RISK_STALE_EN
            // A sample on the channel wins over the stale force in the same cycle.
            stale_d[c] = stale_q[c];
            if (hit[c]) begin
                stale_d[c] = '0;
            end else if (stale_q[c] != StaleMax) begin
                stale_d[c] = stale_q[c] + 1'b1;
                if (stale_d[c] == StaleMax) begin
                    flag_d[c] = 1'b1;
                    dis_d[c]  = '0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int c = 0; c < 6; c++) begin
                dis_q[c] <= '0;
`ifdef RISK_STALE_EN
                stale_q[c] <= '0;
`endif
            end
        end else begin
            flag_q <= flag_d;
            err_q  <= accept & (s_chan > 3'd5);
            done_q <= accept & (s_chan == 3'd5);
            for (int c = 0; c < 6; c++) begin
                dis_q[c] <= dis_d[c];
`ifdef RISK_STALE_EN
                stale_q[c] <= stale_d[c];
`endif
            end
        end
    end

    assign H         = flag_q[0];
    assign P         = flag_q[1];
    assign O         = flag_q[2];
    assign T         = flag_q[3];
    assign R         = flag_q[4];
    assign B         = flag_q[5];
    assign err_chan  = err_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_vital_risk_encoder.sv
module tb_vital_risk_encoder;

    localparam logic [71:0] LoLim = {{5{12'd0}}, 12'd50};
    localparam logic [71:0] HiLim = {{5{12'd4095}}, 12'd120};

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  s_chan;
    logic [11:0] s_data;
    logic        H, P, O, T, R, B;
    logic        err_chan, scan_done;

    int errors = 0;
    int checks = 0;

    vital_risk_encoder #(
        .DW        (12),
        .PERSIST   (3),
        .LO_LIMITS (LoLim),
        .HI_LIMITS (HiLim),
        .STALE_CYC (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_chan    (s_chan),
        .s_data    (s_data),
        .H         (H),
        .P         (P),
        .O         (O),
        .T         (T),
        .R         (R),
        .B         (B),
        .err_chan  (err_chan),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one sample for one cycle; returns at posedge+1 with the result visible.
    task automatic send(input logic [2:0] c, input logic [11:0] d);
        s_valid = 1'b1;
        s_chan  = c;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_chan  = 3'd0;
        s_data  = '0;

        // Reset state
        @(posedge clk);
        #1;
        check("ready_in_reset", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        check("flags_reset", 32'({H, P, O, T, R, B}), 32'd0);
        check("err_reset", 32'(err_chan), 32'd0);
        check("done_reset", 32'(scan_done), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after", 32'(s_ready), 32'd1);

        // Persistence: three out-of-range samples raise H
        send(3'd0, 12'd130);
        check("h_oor1", 32'(H), 32'd0);
        send(3'd0, 12'd130);
        check("h_oor2", 32'(H), 32'd0);
        send(3'd0, 12'd130);
        check("h_oor3", 32'(H), 32'd1);
        check("others_hold", 32'({P, O, T, R, B}), 32'd0);

        // Agreeing sample resets the disagreement count
        send(3'd0, 12'd80);
        send(3'd0, 12'd80);
        send(3'd0, 12'd130);
        check("h_agree_reset", 32'(H), 32'd1);
        send(3'd0, 12'd80);
        send(3'd0, 12'd80);
        check("h_clear5", 32'(H), 32'd1);
        send(3'd0, 12'd80);
        check("h_clear6", 32'(H), 32'd0);

        // Inclusive limits, then just below the lower limit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(3'd0, 12'd50);
            send(3'd0, 12'd120);
        end
        check("h_inclusive", 32'(H), 32'd0);
        send(3'd0, 12'd49);
        send(3'd0, 12'd49);
        check("h_low2", 32'(H), 32'd0);
        send(3'd0, 12'd49);
        check("h_low3", 32'(H), 32'd1);

        // Reset mid-stream loses partial counts and discards the reset-cycle sample
        do_reset();
        send(3'd0, 12'd130);
        send(3'd0, 12'd130);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_chan  = 3'd0;
        s_data  = 12'd130;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        check("h_midreset", 32'(H), 32'd0);
        send(3'd0, 12'd130);
        check("h_dis_lost", 32'(H), 32'd0);
        send(3'd0, 12'd130);
        send(3'd0, 12'd130);
        check("h_after_reset3", 32'(H), 32'd1);

        // Illegal channels and scan_done
        do_reset();
        send(3'd6, 12'd0);
        check("err_pulse6", 32'(err_chan), 32'd1);
        check("done_on_err", 32'(scan_done), 32'd0);
        check("flags_on_err", 32'({H, P, O, T, R, B}), 32'd0);
        idle(1);
        check("err_low", 32'(err_chan), 32'd0);
        send(3'd7, 12'd4095);
        check("err_pulse7", 32'(err_chan), 32'd1);
        send(3'd5, 12'd0);
        check("done_pulse", 32'(scan_done), 32'd1);
        check("err_after5", 32'(err_chan), 32'd0);
        check("b_inrange", 32'(B), 32'd0);
        idle(1);
        check("done_low", 32'(scan_done), 32'd0);

        // Stale detection
        do_reset();
`ifdef RISK_STALE_EN
        idle(19);
        check("t_stale19", 32'(T), 32'd0);
        idle(1);
        check("t_stale20", 32'(T), 32'd1);
        check("all_stale", 32'({H, P, O, T, R, B}), 32'h3f);
        send(3'd3, 12'd100);
        send(3'd3, 12'd100);
        check("t_recover2", 32'(T), 32'd1);
        send(3'd3, 12'd100);
        check("t_recover3", 32'(T), 32'd0);
        idle(1);
        check("t_hold", 32'(T), 32'd0);
`else
        idle(25);
        check("t_no_stale", 32'(T), 32'd0);
        check("flags_no_stale", 32'({H, P, O, T, R, B}), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
